axi4_sram_slave: RTL and testbench



---
 rtl/axi4_sram_slave_if.sv | 56 +++++
 rtl/axi4_sram_slave.sv | 206 ++++++++++++++++++++
 tb/tb_axi4_sram_slave.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_sram_slave_if.sv
// AXI4 bundle between the core's io_master port and the SRAM slave model.
interface axi4_sram_slave_if;
  logic        awready;
  logic        awvalid;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wready;
  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bready;
  logic        bvalid;
  logic [3:0]  bid;
  logic [1:0]  bresp;

  logic        arready;
  logic        arvalid;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rready;
  logic        rvalid;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst,
    output rready,
    input  awready, wready, bvalid, bid, bresp,
    input  arready, rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst,
    input  rready,
    output awready, wready, bvalid, bid, bresp,
    output arready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi4_sram_slave.sv
// AXI4 single-port SRAM slave; INCR bursts, one word array shared by read and write channels.
// Latency: first rvalid RD_LAT cycles after AR, bvalid 1 cycle after the last W beat.
// Backpressure: rvalid/rdata held until rready; optional random stalls via AXI_SRAM_RAND_DELAY_EN.
module axi4_sram_slave #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned RD_LAT      = 1
) (
  input logic              clock,
  input logic              reset,
  axi4_sram_slave_if.slave axi
);
  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [7:0]  LAT_INIT = (RD_LAT >= 2) ? 8'(RD_LAT - 2) : 8'd0;

  typedef enum logic [2:0] {IDLE, RLAT, RDATA, WDATA, BRESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] idx_q;
  logic [7:0]  cnt_q;
  logic [7:0]  lat_q;
  logic        err_q;
  logic [3:0]  bid_q, rid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;
  logic        rlast_q;
  logic [2:0]  dly_q, dly_new;

  logic        hold, aw_rdy, ar_rdy;
  logic        aw_hs, ar_hs, w_hs, r_hs, b_hs, mem_we;
  logic        rd_load, dly_load;
  logic [31:0] rd_idx, ar_idx, aw_idx;
  logic [7:0]  rd_cnt;

  function automatic logic in_range(input logic [31:0] i);
    return i < DEPTH_WORDS;
  endfunction

  // Addresses below BASE_ADDR wrap to huge indices and fall out of range naturally.
  function automatic logic [31:0] word_idx(input logic [31:0] a);
    return (a - BASE_ADDR) >> 2;
  endfunction

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clock) begin
    if (!reset) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign dly_new = lfsr_q[2:0];
`else
  assign dly_new = 3'd0;
`endif

  assign ar_idx = word_idx(axi.araddr);
  assign aw_idx = word_idx(axi.awaddr);

  assign hold   = (dly_q != 3'd0);
  assign aw_rdy = (state_q == IDLE) && !hold;
  // Write wins a tie, so arready must drop in the same cycle awvalid appears.
  assign ar_rdy = aw_rdy && !axi.awvalid;

  assign aw_hs  = aw_rdy && axi.awvalid;
  assign ar_hs  = ar_rdy && axi.arvalid;
  assign w_hs   = (state_q == WDATA) && axi.wvalid;
  assign r_hs   = (state_q == RDATA) && !hold && axi.rready;
  assign b_hs   = (state_q == BRESP) && !hold && axi.bready;
  assign mem_we = reset && w_hs && in_range(idx_q);

  assign axi.awready = aw_rdy;
  assign axi.arready = ar_rdy;
  assign axi.wready  = (state_q == WDATA);
  assign axi.bvalid  = (state_q == BRESP) && !hold;
  assign axi.rvalid  = (state_q == RDATA) && !hold;
  assign axi.bid     = bid_q;
  assign axi.bresp   = bresp_q;
  assign axi.rid     = rid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.rlast   = rlast_q;

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    rd_load  = 1'b0;
    rd_idx   = idx_q;
    rd_cnt   = cnt_q;
    dly_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (aw_hs) begin
          state_d = WDATA;
        end else if (ar_hs) begin
          dly_load = 1'b1;
          if (RD_LAT == 1) begin
            state_d = RDATA;
            rd_load = 1'b1;
            rd_idx  = ar_idx;
            rd_cnt  = axi.arlen;
          end else begin
            state_d = RLAT;
          end
        end
      end
      RLAT: begin
        if (lat_q == 8'd0 && !hold) begin
          state_d = RDATA;
          rd_load = 1'b1;
        end
      end
      RDATA: begin
        if (r_hs) begin
          dly_load = 1'b1;
          if (cnt_q == 8'd0) begin
            state_d = IDLE;
          end else begin
            rd_load = 1'b1;
            rd_idx  = idx_q + 32'd1;
            rd_cnt  = cnt_q - 8'd1;
          end
        end
      end
      WDATA: begin
        if (w_hs && axi.wlast) begin
          state_d  = BRESP;
          dly_load = 1'b1;
        end
      end
      BRESP: begin
        if (b_hs) begin
          state_d  = IDLE;
          dly_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
      bid_q   <= '0;
      bresp_q <= '0;
      rid_q   <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
      rlast_q <= 1'b0;
      dly_q   <= '0;
    end else begin
      if (dly_load)            dly_q <= dly_new;
      else if (dly_q != 3'd0)  dly_q <= dly_q - 3'd1;

      if (aw_hs) begin
        bid_q <= axi.awid;
        idx_q <= aw_idx;
        err_q <= 1'b0;
      end
      if (ar_hs) begin
        rid_q <= axi.arid;
        idx_q <= ar_idx;
        cnt_q <= axi.arlen;
        lat_q <= LAT_INIT;
      end
      if (state_q == RLAT && lat_q != 8'd0) lat_q <= lat_q - 8'd1;

      // rdata is registered per beat so it stays put while the master stalls.
      if (rd_load) begin
        idx_q   <= rd_idx;
        cnt_q   <= rd_cnt;
        rdata_q <= in_range(rd_idx) ? mem[rd_idx[AW-1:0]] : 32'd0;
        rresp_q <= in_range(rd_idx) ? 2'b00 : 2'b11;
        rlast_q <= (rd_cnt == 8'd0);
      end

      if (w_hs) begin
        idx_q <= idx_q + 32'd1;
        if (!in_range(idx_q)) err_q <= 1'b1;
        if (axi.wlast) bresp_q <= (err_q || !in_range(idx_q)) ? 2'b11 : 2'b00;
      end
    end
  end

  // Array has no reset so contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (axi.wstrb[b]) mem[idx_q[AW-1:0]][8*b +: 8] <= axi.wdata[8*b +: 8];
      end
    end
  end

  logic unused_sig;
  assign unused_sig = ^{axi.awlen, axi.awsize, axi.awburst, axi.arsize, axi.arburst};

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave: expected R/B responses are queued at issue time
// and a negedge monitor pops and compares them at each handshake.
module tb_axi4_sram_slave;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  rexp_t rq[$];
  bexp_t bq[$];
  rexp_t re;
  bexp_t be;
  logic        stall_q   = 1'b0;
  logic [31:0] stall_dat = '0;

  axi4_sram_slave_if axi();

  axi4_sram_slave #(
    .DEPTH_WORDS(4096),
    .BASE_ADDR  (32'h8000_0000),
    .RD_LAT     (1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .axi  (axi)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: compares every R/B handshake against the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      if (stall_q) begin
        chk("r_hold_vld", 32'(axi.rvalid), 32'd1);
        chk("r_hold_dat", axi.rdata, stall_dat);
      end
      stall_q   = reset && axi.rvalid && !axi.rready;
      stall_dat = axi.rdata;
      if (reset && axi.rvalid && axi.rready) begin
        if (rq.size() == 0) begin
          chk("r_unexpected", 32'd1, 32'd0);
        end else begin
          re = rq.pop_front();
          chk("rid",   32'(axi.rid),   32'(re.id));
          chk("rdata", axi.rdata,      re.data);
          chk("rresp", 32'(axi.rresp), 32'(re.resp));
          chk("rlast", 32'(axi.rlast), 32'(re.last));
        end
      end
      if (reset && axi.bvalid && axi.bready) begin
        if (bq.size() == 0) begin
          chk("b_unexpected", 32'd1, 32'd0);
        end else begin
          be = bq.pop_front();
          chk("bid",   32'(axi.bid),   32'(be.id));
          chk("bresp", 32'(axi.bresp), 32'(be.resp));
        end
      end
    end
  end

  task automatic drain(input bit toggle);
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 200) begin
      @(posedge clock); #1;
      axi.rready = toggle ? ~axi.rready : 1'b1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 32'(rq.size() + bq.size()), 32'd0);
    axi.rready = 1'b1;
  endtask

  task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    bit ok = 1'b0;
    axi.arvalid = 1'b1; axi.arid = id; axi.araddr = addr; axi.arlen = len;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clock); ok = axi.arready;
      @(posedge clock); #1;
    end
    axi.arvalid = 1'b0;
    chk("ar_handshake", 32'(ok), 32'd1);
    chk("r_first_lat", 32'(axi.rvalid), 32'd1);
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input bit toggle);
    issue_ar(id, addr, len);
    drain(toggle);
  endtask

  task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic [1:0] resp);
    bit ok = 1'b0;
    bq.push_back('{id, resp});
    axi.awvalid = 1'b1; axi.awid = id; axi.awaddr = addr; axi.awlen = 8'd0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clock); ok = axi.awready;
      @(posedge clock); #1;
    end
    axi.awvalid = 1'b0;
    chk("aw_handshake", 32'(ok), 32'd1);
    ok = 1'b0;
    axi.wvalid = 1'b1; axi.wdata = data; axi.wstrb = strb; axi.wlast = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clock); ok = axi.wready;
      @(posedge clock); #1;
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    chk("w_handshake", 32'(ok), 32'd1);
    chk("b_lat", 32'(axi.bvalid), 32'd1);
    drain(1'b0);
  endtask

  initial begin
    bit ar_done, aw_f, w_f, ar_f;
    axi.awvalid = 0; axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 3'd2; axi.awburst = 2'd1;
    axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.bready = 1;
    axi.arvalid = 0; axi.arid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 3'd2; axi.arburst = 2'd1;
    axi.rready = 1;

    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rst_rvalid",  32'(axi.rvalid),  32'd0);
    chk("rst_bvalid",  32'(axi.bvalid),  32'd0);
    chk("rst_wready",  32'(axi.wready),  32'd0);
    chk("rst_arready", 32'(axi.arready), 32'd1);
    chk("rst_awready", 32'(axi.awready), 32'd1);
    chk("rst_rdata",   axi.rdata,        32'd0);
    @(posedge clock); #1;

    // Partial-strobe write over a zeroed word.
    wr(4'd3, 32'h8000_0004, 32'h0000_0000, 4'hF, 2'b00);
    wr(4'd3, 32'h8000_0004, 32'hDEAD_BEEF, 4'b0011, 2'b00);
    rq.push_back('{4'd4, 32'h0000_BEEF, 2'b00, 1'b1});
    rd(4'd4, 32'h8000_0004, 8'd0, 1'b0);

    // IFU-style 4-beat burst with rready toggling.
    wr(4'd1, 32'h8000_0000, 32'hA5A5_0000, 4'hF, 2'b00);
    wr(4'd1, 32'h8000_0008, 32'h1234_5678, 4'hF, 2'b00);
    wr(4'd1, 32'h8000_000C, 32'hCAFE_F00D, 4'hF, 2'b00);
    rq.push_back('{4'd2, 32'hA5A5_0000, 2'b00, 1'b0});
    rq.push_back('{4'd2, 32'h0000_BEEF, 2'b00, 1'b0});
    rq.push_back('{4'd2, 32'h1234_5678, 2'b00, 1'b0});
    rq.push_back('{4'd2, 32'hCAFE_F00D, 2'b00, 1'b1});
    rd(4'd2, 32'h8000_0000, 8'd3, 1'b1);

    // Simultaneous AW and AR: write first, AR only after the B handshake.
    bq.push_back('{4'd6, 2'b00});
    rq.push_back('{4'd5, 32'h0BAD_F00D, 2'b00, 1'b1});
    axi.awvalid = 1; axi.awid = 4'd6; axi.awaddr = 32'h8000_0010;
    axi.wvalid = 1; axi.wdata = 32'h0BAD_F00D; axi.wstrb = 4'hF; axi.wlast = 1;
    axi.arvalid = 1; axi.arid = 4'd5; axi.araddr = 32'h8000_0010; axi.arlen = 0;
    @(negedge clock);
    chk("tie_awready", 32'(axi.awready), 32'd1);
    chk("tie_arready", 32'(axi.arready), 32'd0);
    ar_done = 0;
    for (int c = 0; c < 40 && !ar_done; c++) begin
      if (c != 0) @(negedge clock);
      aw_f = axi.awvalid && axi.awready;
      w_f  = axi.wvalid && axi.wready;
      ar_f = axi.arvalid && axi.arready;
      if (ar_f) chk("ar_after_b", 32'(bq.size()), 32'd0);
      @(posedge clock); #1;
      if (aw_f) axi.awvalid = 0;
      if (w_f) begin axi.wvalid = 0; axi.wlast = 0; end
      if (ar_f) begin axi.arvalid = 0; ar_done = 1; end
    end
    chk("tie_ar_done", 32'(ar_done), 32'd1);
    drain(1'b0);

    // Range boundaries: last word, burst running off the end, below base, past end.
    wr(4'd7, 32'h8000_3FFC, 32'h5EED_1234, 4'hF, 2'b00);
    rq.push_back('{4'd8, 32'h5EED_1234, 2'b00, 1'b0});
    rq.push_back('{4'd8, 32'h0000_0000, 2'b11, 1'b1});
    rd(4'd8, 32'h8000_3FFC, 8'd1, 1'b0);
    rq.push_back('{4'd9, 32'h0000_0000, 2'b11, 1'b1});
    rd(4'd9, 32'h7FFF_FFFC, 8'd0, 1'b0);
    rq.push_back('{4'd9, 32'h0000_0000, 2'b11, 1'b1});
    rd(4'd9, 32'h8000_4000, 8'd0, 1'b0);
    wr(4'd10, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 2'b11);
    rq.push_back('{4'd10, 32'hA5A5_0000, 2'b00, 1'b1});
    rd(4'd10, 32'h8000_0000, 8'd0, 1'b0);

    // Reset while beat 2 of 4 is presented.
    rq.push_back('{4'd11, 32'hA5A5_0000, 2'b00, 1'b0});
    axi.rready = 1'b0;
    issue_ar(4'd11, 32'h8000_0000, 8'd3);
    axi.rready = 1'b1;
    @(posedge clock); #1;
    chk("mid_beat2_vld", 32'(axi.rvalid), 32'd1);
    axi.rready = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("mid_rst_rvalid",  32'(axi.rvalid),  32'd0);
    chk("mid_rst_arready", 32'(axi.arready), 32'd1);
    chk("mid_rst_sb",      32'(rq.size()),   32'd0);
    reset = 1'b1;
    axi.rready = 1'b1;
    rq.push_back('{4'd12, 32'h1234_5678, 2'b00, 1'b1});
    rd(4'd12, 32'h8000_0008, 8'd0, 1'b0);

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
